// File: rtl/bcd_to_bin.sv
// Digit-serial signed-magnitude BCD to two's complement converter (reverse double dabble).
// Optional range/digit checking is compiled in with BCD_TO_BIN_RANGE_CHECK_EN.
`ifndef RES_WIDTH
`define RES_WIDTH 16
`endif
`ifndef DECIMAL_DIGITS
`define DECIMAL_DIGITS 5
`endif

module bcd_to_bin #(
  parameter int BIN_WIDTH = `RES_WIDTH,
  parameter int DIGITS    = `DECIMAL_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  start_i,
  input  logic [DIGITS*4-1:0]   BCD_i,
  input  logic                  sign_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [BIN_WIDTH-1:0]  binary_o,
  output logic                  err_o
);

  localparam int CW = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_SHIFT = CW'(BIN_WIDTH - 1);
  localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_SHIFT = 5'b00010;
  localparam logic [4:0] S_DCHK  = 5'b00100;
  localparam logic [4:0] S_SIGN  = 5'b01000;
  localparam logic [4:0] S_DONE  = 5'b10000;

  logic [4:0]           state_q, state_d;
  logic [DIGITS*4-1:0]  bcd_q, bcd_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic                 sgn_q, sgn_d;
  logic [CW-1:0]        loop_q, loop_d;
  logic [DW-1:0]        idx_q, idx_d;
  logic                 done_q, done_d;
  logic [BIN_WIDTH-1:0] binary_q, binary_d;
  logic [3:0]           cur_digit;

  assign cur_digit = bcd_q[{idx_q, 2'b00} +: 4];
  assign ready_o   = (state_q == S_IDLE);
  assign done_o    = done_q;
  assign binary_o  = binary_q;

`ifdef BCD_TO_BIN_RANGE_CHECK_EN
  logic err_q, err_d;
  logic erro_q, erro_d;
  logic bad_digit;
  logic ovf;

  always_comb begin
    bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (BCD_i[d*4 +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // A negative result may reach -2^(W-1); a positive one may not.
  assign ovf = (bcd_q != '0) ||
               (sgn_q ? (bin_q[BIN_WIDTH-1] && (bin_q[BIN_WIDTH-2:0] != '0))
                      : bin_q[BIN_WIDTH-1]);
  assign err_o = erro_q;
`else
  assign err_o = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    sgn_d    = sgn_q;
    loop_d   = loop_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    binary_d = binary_q;
`ifdef BCD_TO_BIN_RANGE_CHECK_EN
    err_d    = err_q;
    erro_d   = erro_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          bcd_d   = BCD_i;
          sgn_d   = sign_i;
          bin_d   = '0;
          loop_d  = '0;
          idx_d   = '0;
          state_d = S_SHIFT;
`ifdef BCD_TO_BIN_RANGE_CHECK_EN
          err_d = bad_digit;
          if (bad_digit) state_d = S_DONE;
`endif
        end
      end
      S_SHIFT: begin
        {bcd_d, bin_d} = {bcd_q, bin_q} >> 1;
        if (loop_q == LAST_SHIFT) begin
          state_d = S_SIGN;
        end else begin
          loop_d  = loop_q + 1'b1;
          idx_d   = '0;
          state_d = S_DCHK;
        end
      end
      S_DCHK: begin
        if (cur_digit >= 4'd8) bcd_d[{idx_q, 2'b00} +: 4] = cur_digit - 4'd3;
        if (idx_q == LAST_DIGIT) state_d = S_SHIFT;
        else                     idx_d   = idx_q + 1'b1;
      end
      S_SIGN: begin
        if (sgn_q) bin_d = ~bin_q + 1'b1;
`ifdef BCD_TO_BIN_RANGE_CHECK_EN
        err_d = ovf;
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        binary_d = bin_q;
`ifdef BCD_TO_BIN_RANGE_CHECK_EN
        if (err_q) binary_d = '0;
        erro_d = err_q;
`endif
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i && (state_q == S_SHIFT || state_q == S_DCHK || state_q == S_SIGN))
      state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      bcd_q    <= '0;
      bin_q    <= '0;
      sgn_q    <= 1'b0;
      loop_q   <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      binary_q <= '0;
`ifdef BCD_TO_BIN_RANGE_CHECK_EN
      err_q    <= 1'b0;
      erro_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      sgn_q    <= sgn_d;
      loop_q   <= loop_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      binary_q <= binary_d;
`ifdef BCD_TO_BIN_RANGE_CHECK_EN
      err_q    <= err_d;
      erro_q   <= erro_d;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Bench for bcd_to_bin (16-bit result, 5 digits): directed table, corner sequences, random vs arithmetic model.
module tb_bcd_to_bin;
  localparam int W   = 16;
  localparam int D   = 5;
  localparam int LAT = W + (W - 1) * D + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush_i = 1'b0;
  logic         start_i = 1'b0;
  logic [19:0]  BCD_i = '0;
  logic         sign_i = 1'b0;
  logic         ready_o, done_o, err_o;
  logic [15:0]  binary_o;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_to_bin #(.BIN_WIDTH(W), .DIGITS(D)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .start_i(start_i),
    .BCD_i(BCD_i), .sign_i(sign_i), .ready_o(ready_o), .done_o(done_o),
    .binary_o(binary_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] bcd;
    logic        sgn;
    logic [15:0] exp_bin;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Expected result from the decimal value itself, not from the shift algorithm.
  function automatic void model(input logic [19:0] b, input logic s,
                                output logic [15:0] r, output logic e);
    int mag = 0;
    bit bad = 0;
    logic [15:0] m16;
    for (int d = D - 1; d >= 0; d--) begin
      int dg = int'(b[d*4 +: 4]);
      if (dg > 9) bad = 1;
      mag = mag * 10 + dg;
    end
    e = 1'b0;
`ifdef BCD_TO_BIN_RANGE_CHECK_EN
    if (bad || (!s && mag > 32767) || (s && mag > 32768)) begin
      r = '0;
      e = 1'b1;
      return;
    end
`endif
    m16 = 16'(mag);
    r = s ? (~m16 + 16'd1) : m16;
  endfunction

  task automatic conv(input logic [19:0] b, input logic s,
                      output logic [15:0] rb, output logic re, output int lat);
    int w = 0;
    while (!ready_o && w < 300) begin
      @(posedge clk); #1; w++;
    end
    BCD_i = b; sign_i = s; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!done_o && lat < 300);
    rb = binary_o;
    re = err_o;
    chk("ready_with_done", {31'd0, ready_o}, 32'd1);
  endtask

  vec_t        tbl[$];
  logic [15:0] rb, eb, prev;
  logic        re, ee;
  int          lat, ndone;

  initial begin
    tbl.push_back('{20'h12345, 1'b0, 16'h3039, 1'b0, LAT});
    tbl.push_back('{20'h00128, 1'b1, 16'hFF80, 1'b0, LAT});
    tbl.push_back('{20'h32768, 1'b1, 16'h8000, 1'b0, LAT});
    tbl.push_back('{20'h32767, 1'b0, 16'h7FFF, 1'b0, LAT});
    tbl.push_back('{20'h00000, 1'b1, 16'h0000, 1'b0, LAT});
    tbl.push_back('{20'h00001, 1'b1, 16'hFFFF, 1'b0, LAT});
    tbl.push_back('{20'h00000, 1'b0, 16'h0000, 1'b0, LAT});
`ifdef BCD_TO_BIN_RANGE_CHECK_EN
    tbl.push_back('{20'h32768, 1'b0, 16'h0000, 1'b1, LAT});
    tbl.push_back('{20'h32769, 1'b1, 16'h0000, 1'b1, LAT});
    tbl.push_back('{20'h99999, 1'b0, 16'h0000, 1'b1, LAT});
    tbl.push_back('{20'h65536, 1'b1, 16'h0000, 1'b1, LAT});
    tbl.push_back('{20'h0A001, 1'b0, 16'h0000, 1'b1, 1});
`else
    tbl.push_back('{20'h32768, 1'b0, 16'h8000, 1'b0, LAT});
    tbl.push_back('{20'h32769, 1'b1, 16'h7FFF, 1'b0, LAT});
    tbl.push_back('{20'h99999, 1'b0, 16'h869F, 1'b0, LAT});
    tbl.push_back('{20'h65536, 1'b1, 16'h0000, 1'b0, LAT});
`endif

    #12 rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_ready", {31'd0, ready_o}, 32'd1);
    chk("reset_done", {31'd0, done_o}, 32'd0);
    chk("reset_bin", {16'd0, binary_o}, 32'd0);
    chk("reset_err", {31'd0, err_o}, 32'd0);

    foreach (tbl[i]) begin
      conv(tbl[i].bcd, tbl[i].sgn, rb, re, lat);
      chk($sformatf("tbl%0d_bin", i), {16'd0, rb}, {16'd0, tbl[i].exp_bin});
      chk($sformatf("tbl%0d_err", i), {31'd0, re}, {31'd0, tbl[i].exp_err});
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_lat);
    end

    // done_o lasts one cycle and the result holds afterwards
    conv(20'h12345, 1'b0, rb, re, lat);
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done_o}, 32'd0);
    chk("bin_hold", {16'd0, binary_o}, 32'h3039);

    // start while busy is ignored
    BCD_i = 20'h00128; sign_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 BCD_i = 20'h00777; sign_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 6;
    do begin
      @(posedge clk); #1; lat++;
    end while (!done_o && lat < 300);
    chk("busy_start_lat", lat, LAT);
    chk("busy_start_bin", {16'd0, binary_o}, 32'h0000FF80);
    @(posedge clk); #1;
    chk("busy_start_no_second", {31'd0, ready_o}, 32'd1);

    // flush mid-conversion
    prev = binary_o;
    BCD_i = 20'h12345; sign_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_ready", {31'd0, ready_o}, 32'd1);
    ndone = 0;
    repeat (120) begin
      @(posedge clk); #1;
      if (done_o) ndone++;
    end
    chk("flush_no_done", ndone, 0);
    chk("flush_bin_kept", {16'd0, binary_o}, {16'd0, prev});
    conv(20'h00128, 1'b1, rb, re, lat);
    chk("after_flush_bin", {16'd0, rb}, 32'h0000FF80);
    chk("after_flush_lat", lat, LAT);

    // asynchronous reset mid-conversion
    BCD_i = 20'h12345; sign_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    chk("midrst_ready", {31'd0, ready_o}, 32'd1);
    chk("midrst_done", {31'd0, done_o}, 32'd0);
    chk("midrst_bin", {16'd0, binary_o}, 32'd0);
    chk("midrst_err", {31'd0, err_o}, 32'd0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    conv(20'h32767, 1'b1, rb, re, lat);
    chk("after_rst_bin", {16'd0, rb}, 32'h00008001);

    // back-to-back random conversions against the arithmetic model
    for (int k = 0; k < 40; k++) begin
      logic [19:0] b;
      logic        s;
      for (int d = 0; d < D; d++) begin
        logic [3:0] dg;
        dg = 4'($urandom_range(0, 9));
`ifdef BCD_TO_BIN_RANGE_CHECK_EN
        if ($urandom_range(0, 19) == 0) dg = 4'($urandom_range(10, 15));
`endif
        b[d*4 +: 4] = dg;
      end
      s = 1'($urandom_range(0, 1));
      model(b, s, eb, ee);
      conv(b, s, rb, re, lat);
      chk($sformatf("rnd%0d_bin(%05h,%0d)", k, b, s), {16'd0, rb}, {16'd0, eb});
      chk($sformatf("rnd%0d_err", k), {31'd0, re}, {31'd0, ee});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
